cache_meta_array: RTL

//  Parametrised cache metadata/data array (tag, valid, dirty, LRU fields) with
//  1 read and 1 write port, combinational read with write-to-read bypass,
//  per-bit write mask for partial field updates, and a multi-cycle flush engine

---
 rtl/cache_meta_array_if.sv | 27 ++
 rtl/cache_meta_array.sv | 90 +++++++++
 2 files changed

// File: rtl/cache_meta_array_if.sv
// Read/write/flush port bundle for one cache metadata array way.
// The controller drives the master side and the array is the slave.
interface cache_meta_array_if #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 8
);
   localparam int unsigned IDX_W = $clog2(DEPTH);

   logic             load;
   logic [IDX_W-1:0] windex;
   logic [WIDTH-1:0] wmask;
   logic [WIDTH-1:0] datain;
   logic [IDX_W-1:0] rindex;
   logic [WIDTH-1:0] dataout;
   logic             flush;
   logic             busy;

   modport master (
      output load, windex, wmask, datain, rindex, flush,
      input  dataout, busy
   );

   modport slave (
      input  load, windex, wmask, datain, rindex, flush,
      output dataout, busy
   );
endinterface

// File: rtl/cache_meta_array.sv
// Cache metadata array with masked writes, write-to-read bypass on the combinational read,
// and a flush engine that clears one entry per cycle while busy is high.
module cache_meta_array #(
   parameter int unsigned      WIDTH     = 1,
   parameter int unsigned      DEPTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input logic               clk,
   input logic               rst,
   cache_meta_array_if.slave bus
);
   localparam int unsigned      IDX_W    = $clog2(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IDX_W-1:0] r_clr_idx;
   logic [IDX_W-1:0] w_clr_idx_nxt;
   logic [WIDTH-1:0] r_mem [DEPTH];

   logic             w_wr_en;
   logic [IDX_W-1:0] w_wr_idx;
   logic [WIDTH-1:0] w_wr_data;
   logic [WIDTH-1:0] w_merged;
   logic             w_bypass;
   logic             w_busy;

   // Masked merge of the incoming write with the addressed entry
   assign w_merged = (r_mem[bus.windex] & ~bus.wmask) | (bus.datain & bus.wmask);
   assign w_busy   = (r_state == ST_CLEAR);
   assign w_bypass = (r_state == ST_IDLE) && bus.load && !bus.flush &&
                     (bus.rindex == bus.windex);

   always_comb begin
      w_state_nxt   = r_state;
      w_clr_idx_nxt = r_clr_idx;
      w_wr_en       = 1'b0;
      w_wr_idx      = bus.windex;
      w_wr_data     = w_merged;
      case (r_state)
         ST_IDLE: begin
            // Flush wins over a same-cycle load
            if (bus.flush) begin
               w_state_nxt   = ST_CLEAR;
               w_clr_idx_nxt = '0;
            end else if (bus.load) begin
               w_wr_en = 1'b1;
            end
         end
         ST_CLEAR: begin
            w_wr_en       = 1'b1;
            w_wr_idx      = r_clr_idx;
            w_wr_data     = RESET_VAL;
            w_clr_idx_nxt = r_clr_idx + IDX_W'(1);
            if (r_clr_idx == LAST_IDX) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_clr_idx <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[i] <= RESET_VAL;
         end
      end else begin
         r_state   <= w_state_nxt;
         r_clr_idx <= w_clr_idx_nxt;
         if (w_wr_en) begin
            r_mem[w_wr_idx] <= w_wr_data;
         end
      end
   end

   // Entries mid-clear are hidden so readers never see a half-flushed array
   assign bus.busy    = w_busy;
   assign bus.dataout = w_busy   ? RESET_VAL :
                        w_bypass ? w_merged  : r_mem[bus.rindex];
endmodule
